// File: rtl/ring_mem_requester.sv
// Ring station that issues one cache-line read or writeback at a time: it seizes the token,
// sends an Address slot (plus WriteData slots for writes), releases the token and collects read returns.
module ring_mem_requester #(
  parameter logic [3:0] T_NULL     = 4'h0,
  parameter logic [3:0] T_TOKEN    = 4'h1,
  parameter logic [3:0] T_ADDR     = 4'h2,
  parameter logic [3:0] T_WDATA    = 4'h3,
  parameter int         LINE_WORDS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  whichCore,
  input  logic [31:0] RingIn,
  input  logic [3:0]  SlotTypeIn,
  input  logic [3:0]  SourceIn,
  output logic [31:0] RingOut,
  output logic [3:0]  SlotTypeOut,
  output logic [3:0]  SourceOut,
  input  logic [31:0] RDreturn,
  input  logic [3:0]  RDdest,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_excl,
  input  logic [27:0] req_line,
  input  logic [31:0] wr_data,
  output logic        wr_data_rd,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic [7:0]  retries
);

  localparam int CW = $clog2(LINE_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  // SEND_ADDR is never entered: the Address slot goes out in the token's own slot.
  typedef enum logic [2:0] {IDLE, WAIT_TOKEN, SEND_ADDR, SEND_DATA, RELEASE, WAIT_RD} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [7:0]     retries_q, retries_d;
  logic           write_q, write_d;
  logic           excl_q, excl_d;
  logic [27:0]    line_q, line_d;
  logic           tok_held_q, tok_held_d;
  logic           done_q, done_d;

  logic           retry_hit;
  logic           retry_ok;
  logic           take_slot;
  logic           my_rd;
  logic [31:0]    addr_word;
  logic [7:0]     retries_inc;

  assign retry_hit   = (SlotTypeIn == T_ADDR) && (RingIn[31:30] == 2'b10) && (SourceIn == whichCore);
  assign retry_ok    = retry_hit && ((state_q == WAIT_RD) || (state_q == RELEASE && !write_q));
  // A retry seen while still holding the token re-issues at the next free slot instead of a Token.
  assign take_slot   = tok_held_q ? (SlotTypeIn == T_NULL) : (SlotTypeIn == T_TOKEN);
  assign my_rd       = (state_q == WAIT_RD) && (RDdest == whichCore);
  assign addr_word   = {2'b00, excl_q, ~write_q, line_q};
  assign retries_inc = (retries_q == 8'hFF) ? 8'hFF : retries_q + 8'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      retries_q  <= '0;
      write_q    <= 1'b0;
      excl_q     <= 1'b0;
      line_q     <= '0;
      tok_held_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      write_q    <= write_d;
      excl_q     <= excl_d;
      line_q     <= line_d;
      tok_held_q <= tok_held_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retries_d  = retries_q;
    write_d    = write_q;
    excl_d     = excl_q;
    line_d     = line_q;
    tok_held_d = tok_held_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          excl_d     = req_excl;
          line_d     = req_line;
          retries_d  = '0;
          cnt_d      = '0;
          tok_held_d = 1'b0;
          state_d    = WAIT_TOKEN;
        end
      end
      WAIT_TOKEN: begin
        if (take_slot) begin
          tok_held_d = 1'b1;
          cnt_d      = '0;
          state_d    = write_q ? SEND_DATA : RELEASE;
        end
      end
      SEND_DATA: begin
        if (SlotTypeIn == T_NULL) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = RELEASE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RELEASE: begin
        if (SlotTypeIn == T_NULL) begin
          tok_held_d = 1'b0;
          if (write_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RD;
          end
        end else if (retry_ok) begin
          retries_d = retries_inc;
          cnt_d     = '0;
          state_d   = WAIT_TOKEN;
        end
      end
      WAIT_RD: begin
        if (retry_ok) begin
          retries_d = retries_inc;
          cnt_d     = '0;
          state_d   = WAIT_TOKEN;
        end else if (my_rd) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    RingOut     = RingIn;
    SlotTypeOut = SlotTypeIn;
    SourceOut   = SourceIn;
    wr_data_rd  = 1'b0;
    case (state_q)
      WAIT_TOKEN: begin
        if (take_slot) begin
          RingOut     = addr_word;
          SlotTypeOut = T_ADDR;
          SourceOut   = whichCore;
        end
      end
      SEND_DATA: begin
        if (SlotTypeIn == T_NULL) begin
          RingOut     = wr_data;
          SlotTypeOut = T_WDATA;
          SourceOut   = whichCore;
          wr_data_rd  = 1'b1;
        end
      end
      RELEASE: begin
        if (SlotTypeIn == T_NULL) begin
          RingOut     = '0;
          SlotTypeOut = T_TOKEN;
          SourceOut   = '0;
        end else if (retry_ok) begin
          RingOut     = '0;
          SlotTypeOut = T_NULL;
          SourceOut   = '0;
        end
      end
      WAIT_RD: begin
        if (retry_ok) begin
          RingOut     = '0;
          SlotTypeOut = T_NULL;
          SourceOut   = '0;
        end
      end
      default: ;
    endcase
    if (reset) begin
      RingOut     = '0;
      SlotTypeOut = T_NULL;
      SourceOut   = '0;
      wr_data_rd  = 1'b0;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rd_valid  = my_rd && !reset;
  assign rd_data   = RDreturn;
  assign done      = done_q;
  assign retries   = retries_q;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      if (retry_ok && state_q == WAIT_RD && cnt_q != '0)
        $display("ring_mem_requester core %0d: protocol warning, retry after %0d data words", whichCore, cnt_q);
      if (RDdest == whichCore && state_q != WAIT_RD)
        $display("ring_mem_requester core %0d: warning, unexpected read return %08h ignored", whichCore, RDreturn);
    end
  end
`endif

endmodule

// File: tb/tb_ring_mem_requester.sv
// Scoreboard bench for ring_mem_requester: expected ring slots and read words are queued
// as stimulus is driven and popped by a monitor as the station produces them.
module tb_ring_mem_requester;

  localparam logic [3:0] T_NULL  = 4'h0;
  localparam logic [3:0] T_TOKEN = 4'h1;
  localparam logic [3:0] T_ADDR  = 4'h2;
  localparam logic [3:0] T_WDATA = 4'h3;
  localparam logic [3:0] ME      = 4'd3;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] RingIn;
  logic [3:0]  SlotTypeIn, SourceIn;
  logic [31:0] RingOut;
  logic [3:0]  SlotTypeOut, SourceOut;
  logic [31:0] RDreturn;
  logic [3:0]  RDdest;
  logic        req_valid, req_ready, req_write, req_excl;
  logic [27:0] req_line;
  logic [31:0] wr_data;
  logic        wr_data_rd;
  logic [31:0] rd_data;
  logic        rd_valid, done;
  logic [7:0]  retries;

  int total = 0;
  int bad = 0;
  int wr_idx = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int wr_start;
  logic [39:0] slot_q[$];
  logic [31:0] rd_q[$];

  ring_mem_requester dut (
    .clock(clock), .reset(reset), .whichCore(ME),
    .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
    .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
    .RDreturn(RDreturn), .RDdest(RDdest),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_excl(req_excl), .req_line(req_line),
    .wr_data(wr_data), .wr_data_rd(wr_data_rd),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .retries(retries)
  );

  always #5 clock = ~clock;

  assign wr_data = 32'hB0 + 32'(wr_idx);
  always @(posedge clock) if (wr_data_rd) wr_idx <= wr_idx + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Monitor: every non-Null slot and every read word must match the head of its queue.
  logic [39:0] mon_s;
  logic [31:0] mon_d;
  always @(negedge clock) begin
    if (!reset) begin
      if (SlotTypeOut != T_NULL) begin
        if (slot_q.size() == 0) chk("slot_extra", {SlotTypeOut, SourceOut, RingOut}, 40'h0);
        else begin
          mon_s = slot_q.pop_front();
          chk("slot", {SlotTypeOut, SourceOut, RingOut}, mon_s);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) chk("rd_extra", rd_data, 32'h0);
        else begin
          mon_d = rd_q.pop_front();
          chk("rd_word", rd_data, mon_d);
        end
      end
      if (done) done_cnt++;
    end
  end

  task automatic push_slot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    slot_q.push_back({t, s, d});
  endtask

  task automatic slot(input logic [3:0] t, input logic [31:0] d, input logic [3:0] s);
    SlotTypeIn = t; RingIn = d; SourceIn = s;
    @(posedge clock); #1;
    SlotTypeIn = T_NULL; RingIn = '0; SourceIn = '0;
  endtask

  task automatic do_req(input logic w, input logic x, input logic [27:0] line);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = w; req_excl = x; req_line = line;
    @(posedge clock); #1;
    req_valid = 1'b0; req_write = 1'b0; req_excl = 1'b0; req_line = '0;
    chk("req_ready_busy", req_ready, 1'b0);
  endtask

  task automatic rd_words(input logic [31:0] base);
    for (int i = 0; i < 8; i++) begin
      RDdest = ME; RDreturn = base + 32'(i);
      rd_q.push_back(base + 32'(i));
      @(posedge clock); #1;
    end
    RDdest = '0; RDreturn = '0;
    @(negedge clock);
    chk("rd_done", done, 1'b1);
    exp_done++;
    @(posedge clock); #1;
    chk("rd_done_once", done, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    SlotTypeIn = T_NULL; RingIn = '0; SourceIn = '0;
    RDreturn = '0; RDdest = '0;
    req_valid = 1'b0; req_write = 1'b0; req_excl = 1'b0; req_line = '0;
    repeat (2) @(posedge clock);
    #1;
    SlotTypeIn = T_TOKEN; RingIn = 32'h5555; SourceIn = 4'd7;
    @(negedge clock);
    chk("rst_slot_null", {SlotTypeOut, SourceOut, RingOut}, 40'h0);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_retries", retries, 8'd0);
    @(posedge clock); #1;
    SlotTypeIn = T_NULL; RingIn = '0; SourceIn = '0;
    reset = 1'b0;
    @(posedge clock); #1;

    // plain read
    do_req(1'b0, 1'b0, 28'h0000123);
    slot(T_NULL, 0, 0);
    push_slot(T_ADDR, 32'h10000123, ME);
    slot(T_TOKEN, 0, 0);
    push_slot(T_TOKEN, 0, 0);
    slot(T_NULL, 0, 0);
    rd_words(32'hA0);

    // write with a foreign slot between Address and data
    wr_start = wr_idx;
    do_req(1'b1, 1'b0, 28'h0000055);
    slot(T_NULL, 0, 0);
    push_slot(T_ADDR, 32'h00000055, ME);
    slot(T_TOKEN, 0, 0);
    push_slot(T_WDATA, 32'hDEAD, 4'd2);
    slot(T_WDATA, 32'hDEAD, 4'd2);
    for (int i = 0; i < 8; i++) begin
      push_slot(T_WDATA, 32'hB0 + 32'(i), ME);
      slot(T_NULL, 0, 0);
    end
    push_slot(T_TOKEN, 0, 0);
    slot(T_NULL, 0, 0);
    @(negedge clock);
    chk("wr_done", done, 1'b1);
    exp_done++;
    chk("wr_pops", 32'(wr_idx - wr_start), 32'd8);
    @(posedge clock); #1;

    // read with two retries and foreign traffic
    do_req(1'b0, 1'b0, 28'h0000123);
    for (int r = 1; r <= 2; r++) begin
      push_slot(T_ADDR, 32'h10000123, ME);
      slot(T_TOKEN, 0, 0);
      push_slot(T_TOKEN, 0, 0);
      slot(T_NULL, 0, 0);
      slot(T_ADDR, 32'h80000123, ME);
      chk("retry_count", retries, 8'(r));
      chk("retry_busy", req_ready, 1'b0);
    end
    push_slot(T_ADDR, 32'h10000123, ME);
    slot(T_TOKEN, 0, 0);
    push_slot(T_TOKEN, 0, 0);
    slot(T_NULL, 0, 0);
    RDdest = 4'd5; RDreturn = 32'hEE;
    @(posedge clock); #1;
    RDdest = '0; RDreturn = '0;
    push_slot(T_ADDR, 32'h80000123, 4'd5);
    slot(T_ADDR, 32'h80000123, 4'd5);
    chk("foreign_retries", retries, 8'd2);
    chk("foreign_busy", req_ready, 1'b0);
    rd_words(32'hC0);

    // exclusive read
    do_req(1'b0, 1'b1, 28'h0000040);
    push_slot(T_ADDR, 32'h30000040, ME);
    slot(T_TOKEN, 0, 0);
    push_slot(T_TOKEN, 0, 0);
    slot(T_NULL, 0, 0);
    rd_words(32'hD0);

    // reset in the middle of a writeback
    do_req(1'b1, 1'b0, 28'h0000077);
    push_slot(T_ADDR, 32'h00000077, ME);
    slot(T_TOKEN, 0, 0);
    for (int i = 0; i < 3; i++) begin
      push_slot(T_WDATA, 32'hB8 + 32'(i), ME);
      slot(T_NULL, 0, 0);
    end
    reset = 1'b1;
    SlotTypeIn = T_WDATA; RingIn = 32'h1234; SourceIn = 4'd2;
    @(negedge clock);
    chk("mid_rst_slot", {SlotTypeOut, SourceOut, RingOut}, 40'h0);
    chk("mid_rst_wrrd", wr_data_rd, 1'b0);
    @(posedge clock); #1;
    chk("mid_rst_ready", req_ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    SlotTypeIn = T_NULL; RingIn = '0; SourceIn = '0;
    @(posedge clock); #1;
    reset = 1'b0;

    // a Token while idle passes straight through
    push_slot(T_TOKEN, 0, 0);
    slot(T_TOKEN, 0, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("slot_q_empty", 32'(slot_q.size()), 32'd0);
    chk("rd_q_empty", 32'(rd_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'(exp_done));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ring_mem_requester.md
Name: ring_mem_requester

Overview:
- Per-core ring station that initiates cache-line transactions toward the ring memory controller.
- Accepts one line request at a time from the core-side cache logic.
- Seizes the token and issues an Address slot; for writes, follows it with 8 WriteData slots, then releases the token.
- For reads, collects 8 words from the pipelined RDreturn bus, re-issuing the request whenever memory bounces it back as a retry Address.

Parameters:
- T_NULL, 4'h0, slot-type code for Null
- T_TOKEN, 4'h1, slot-type code for Token
- T_ADDR, 4'h2, slot-type code for Address
- T_WDATA, 4'h3, slot-type code for WriteData
- LINE_WORDS, 8, words per cache line (power of 2)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- whichCore  in  4  this station's core number (nonzero)
- RingIn  in  32  ring data from upstream
- SlotTypeIn  in  4  ring slot type from upstream
- SourceIn  in  4  ring source/dest from upstream
- RingOut  out  32  ring data downstream (combinational; top level registers it)
- SlotTypeOut  out  4  slot type downstream
- SourceOut  out  4  source downstream
- RDreturn  in  32  read-return data bus
- RDdest  in  4  read-return destination core (0 = idle)
- req_valid  in  1  request pending
- req_ready  out  1  station idle, accepts request
- req_write  in  1  1 = line writeback, 0 = line read
- req_excl  in  1  read for ownership (address bit 29)
- req_line  in  28  line address
- wr_data  in  32  write word, valid in the cycle wr_data_rd is high
- wr_data_rd  out  1  pops one write word
- rd_data  out  32  returned read word
- rd_valid  out  1  rd_data valid
- done  out  1  one-cycle pulse at transaction completion
- retries  out  8  saturating count of retries for the current request

Behaviour:
- Handshake: req_ready=1 only in IDLE. Request accepted on req_valid&req_ready. Fields are latched; the inputs are don't-care afterwards.
- Address word: {1'b0, 1'b0, excl, ~write, line[27:0]}. SourceOut = whichCore on every slot this station originates.
- Default pass-through: outputs = inputs. During reset, outputs = Null/0/0 and every state is cleared.
- States: IDLE, WAIT_TOKEN, SEND_ADDR, SEND_DATA, RELEASE, WAIT_RD.
- IDLE -> WAIT_TOKEN on accept. retries cleared, word counter cleared.
- WAIT_TOKEN: when SlotTypeIn==T_TOKEN, emit the Address slot in the token's place. The token is now held. Go to SEND_DATA if write, else RELEASE.
- SEND_DATA: emit only into incoming Null slots; non-Null incoming slots pass unchanged and emission waits. Per emission: wr_data_rd=1 that cycle, slot T_WDATA carrying wr_data, counter++. After LINE_WORDS emissions go to RELEASE.
- RELEASE: at the first incoming Null slot emit T_TOKEN (data 0, source 0). A write then pulses done and goes to IDLE; a read goes to WAIT_RD.
- WAIT_RD:
  - Each cycle with RDdest==whichCore: rd_valid=1, rd_data=RDreturn, counter++.
  - After the LINE_WORDS-th word, done pulses in the following cycle, then IDLE.
- Retry:
  - Trigger: in WAIT_RD or RELEASE of a read, an incoming slot with SlotTypeIn==T_ADDR, RingIn[31:30]==2'b10, SourceIn==whichCore.
  - That slot is consumed (emit Null).
  - retries increments, saturating at 255. Counter cleared. Go to WAIT_TOKEN.
  - A retry observed after any data word has arrived is a protocol error: $display a message, then the retry is still honoured.
- Slots addressed to other cores, and retries for other cores, always pass through.
- Token never duplicated or lost: exactly one Token emitted per Token consumed.
- A Token arriving in any state other than WAIT_TOKEN passes through.
- RDreturn words arriving outside WAIT_RD with RDdest==whichCore are ignored and a $display warning is issued.
- Reset mid-transaction returns to IDLE immediately. A held token is dropped; the ring top re-injects it after reset.

Test Plan:
- Read, no contention: line 0x0000123, Token at cycle 5 -> Address slot 0x10000123, src=whichCore, emitted cycle 5. Token emitted cycle 6. 8 RDreturn words 0xA0..0xA7 -> 8 rd_valid pulses in order, done one cycle after the last word.
- Write with interleaved traffic: Null, T_WDATA from core 2, Null x8 after the token -> Address, then the foreign slot passes unchanged. 8 WriteData slots hold wr_data 0xB0..0xB7, then Token, then done. wr_data_rd count = 8.
- Retry: return Address 0x80000123 with src=whichCore in WAIT_RD -> that slot becomes Null, retries=1, and the Address is re-issued at the next Token. A second retry gives retries=2.
- Foreign traffic: RDdest=other core and a retry addressed to another core -> no rd_valid, slot passes unchanged, state unchanged.
- Exclusive read: req_excl=1, line 0x0000040 -> Address 0x30000040.
- Reset asserted during SEND_DATA at word 3 -> next cycle req_ready=1, outputs Null while reset is high, no done pulse.
